// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with thresholds, occupancy, sticky errors and optional FWFT
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_en,
  input  logic                       read_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  af_q, af_d, ae_q, ae_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;
  always_comb begin
    rd_acc      = read_en && !empty_q;
    wr_acc      = write_en && (!full_q || read_en);
    wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = (wr_acc && !rd_acc) ? count_q + (AW+1)'(1) :
                  (rd_acc && !wr_acc) ? count_q - (AW+1)'(1) : count_q;
    full_d      = count_d == DEPTH_C;
    empty_d     = count_d == '0;
    af_d        = count_d >= AF_C;
    ae_d        = count_d <= AE_C;
    overflow_d  = overflow_q || (write_en && full_q && !read_en);
    underflow_d = underflow_q || (read_en && empty_q);
    data_d      = rd_acc ? mem[rd_ptr_q] : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr_q] <= data_in;
  end
  // FWFT presents the head directly; forced to zero while empty so reset shows 0
  assign data_out     = FWFT ? (empty_q ? '0 : mem[rd_ptr_q]) : data_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
endmodule
